glitch_pulse_monitor: RTL

//  Capture-side counterpart to the glitch pulse generator: samples an external pulse
//  (the glitch/trigger pin looped back, or the target's response line) and measures

---
 rtl/glitch_pulse_monitor_pkg.sv | 20 ++
 rtl/glitch_pulse_monitor_if.sv | 35 +++
 rtl/glitch_pulse_monitor_sync_edge_detect.sv | 37 +++
 rtl/glitch_pulse_monitor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/glitch_pulse_monitor_pkg.sv
// glitch_mon_pkg: constants shared by the glitch pulse monitor and generator.
//  - FSM state encodings (IDLE/HIGH/LOW)
//  - PULSE_COUNT width
//  - default timing constants (expected width, tolerance, timeout)
package glitch_mon_pkg;

    localparam int PCNT_W = 16;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_EXPECT_WIDTH = 25;
    localparam int DEF_TOLERANCE    = 2;
    localparam int DEF_TIMEOUT_CYC  = 50_000_000;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

endpackage

// File: rtl/glitch_pulse_monitor_if.sv
// glitch_pulse_monitor_if: stimulus and measurement bundle of the pulse monitor.
//  master: drives PULSE_IN / CLEAR, observes results (board bench / testbench)
//  slave : the monitor itself
//  PULSE_IN, CLEAR                          -> monitor
//  HIGH_WIDTH, LOW_WIDTH, MEAS_VALID,
//  WIDTH_OK, MIN_HIGH, MAX_HIGH,
//  PULSE_COUNT, TIMEOUT                     <- monitor
interface glitch_pulse_monitor_if
    import glitch_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic              PULSE_IN;
    logic              CLEAR;
    logic [CNT_W-1:0]  HIGH_WIDTH;
    logic [CNT_W-1:0]  LOW_WIDTH;
    logic              MEAS_VALID;
    logic              WIDTH_OK;
    logic [CNT_W-1:0]  MIN_HIGH;
    logic [CNT_W-1:0]  MAX_HIGH;
    logic [PCNT_W-1:0] PULSE_COUNT;
    logic              TIMEOUT;

    modport master (
        output PULSE_IN, CLEAR,
        input  HIGH_WIDTH, LOW_WIDTH, MEAS_VALID, WIDTH_OK,
               MIN_HIGH, MAX_HIGH, PULSE_COUNT, TIMEOUT
    );

    modport slave (
        input  PULSE_IN, CLEAR,
        output HIGH_WIDTH, LOW_WIDTH, MEAS_VALID, WIDTH_OK,
               MIN_HIGH, MAX_HIGH, PULSE_COUNT, TIMEOUT
    );
endinterface

// File: rtl/glitch_pulse_monitor_sync_edge_detect.sv
// sync_edge_detect: synchronizes an asynchronous level and detects its edges.
//  CLK, RST_N : clock, async active-low reset
//  d          : asynchronous input
//  s          : synchronized level
//  rise, fall : one-cycle edge strobes of s
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   p;
    // Fills with ones after reset; the top bit marks p as holding a real sample.
    // Without it, a line already high at reset release would look like a rise.
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q   <= '0;
            p        <= 1'b0;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d};
            p        <= s;
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = vld_pipe[SYNC_STAGES] &  s & ~p;
    assign fall = vld_pipe[SYNC_STAGES] & ~s &  p;
endmodule

// File: rtl/glitch_pulse_monitor.sv
// glitch_pulse_monitor: measures high/low widths and period count of an external
// pulse in CLK cycles, flags widths outside EXPECT_WIDTH +/- TOLERANCE and a line
// stuck at one level for TIMEOUT_CYC cycles.
//  CLK, RST_N : clock, async active-low reset
//  bus        : glitch_pulse_monitor_if.slave (PULSE_IN/CLEAR in, results out)
module glitch_pulse_monitor
    import glitch_mon_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int EXPECT_WIDTH = DEF_EXPECT_WIDTH,
    parameter int TOLERANCE    = DEF_TOLERANCE,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input logic                  CLK,
    input logic                  RST_N,
    glitch_pulse_monitor_if.slave bus
);
    localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W:0]   EXP_C = (CNT_W+1)'(EXPECT_WIDTH);
    localparam logic [CNT_W:0]   TOL_C = (CNT_W+1)'(TOLERANCE);

    logic              lvl_unused;  // edges carry everything the FSM needs
    logic              rise, fall;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  high_width, low_width, min_high, max_high;
    logic [PCNT_W-1:0] pulse_count;
    logic              meas_valid, width_ok, timeout;
    logic [CNT_W:0]    hw_ext, hw_diff;
    logic              hw_in_win;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .d    (bus.PULSE_IN),
        .s    (lvl_unused),
        .rise (rise),
        .fall (fall)
    );

    // high_width already holds the just-closed high phase when LOW sees the rise.
    always_comb begin
        hw_ext    = {1'b0, high_width};
        hw_diff   = (hw_ext >= EXP_C) ? hw_ext - EXP_C : EXP_C - hw_ext;
        hw_in_win = (hw_diff <= TOL_C);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            high_width  <= '0;
            low_width   <= '0;
            min_high    <= '1;
            max_high    <= '0;
            pulse_count <= '0;
            meas_valid  <= 1'b0;
            width_ok    <= 1'b0;
            timeout     <= 1'b0;
        end else if (bus.CLEAR) begin
            // Beats any edge or timeout arriving in the same cycle.
            state       <= ST_IDLE;
            cnt         <= '0;
            high_width  <= '0;
            low_width   <= '0;
            min_high    <= '1;
            max_high    <= '0;
            pulse_count <= '0;
            meas_valid  <= 1'b0;
            width_ok    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Level ignored here: a partial pulse is never measured.
                    if (rise) begin
                        state <= ST_HIGH;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    // Exiting on reaching TIMEOUT_CYC keeps cnt from ever wrapping.
                    if (cnt == TO_C) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (fall) begin
                        high_width <= cnt;
                        cnt        <= CNT_W'(1);
                        state      <= ST_LOW;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt == TO_C) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (rise) begin
                        low_width  <= cnt;
                        cnt        <= CNT_W'(1);
                        state      <= ST_HIGH;
                        meas_valid <= 1'b1;
                        width_ok   <= hw_in_win;
                        if (high_width < min_high) min_high <= high_width;
                        if (high_width > max_high) max_high <= high_width;
                        if (pulse_count != '1) pulse_count <= pulse_count + PCNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.HIGH_WIDTH  = high_width;
    assign bus.LOW_WIDTH   = low_width;
    assign bus.MEAS_VALID  = meas_valid;
    assign bus.WIDTH_OK    = width_ok;
    assign bus.MIN_HIGH    = min_high;
    assign bus.MAX_HIGH    = max_high;
    assign bus.PULSE_COUNT = pulse_count;
    assign bus.TIMEOUT     = timeout;
endmodule
